// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC gain-compensation block.
package cordic_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned KGAIN_W   = 16;
  localparam logic [KGAIN_W-1:0] KGAIN_DEF = 16'h9B74;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cordic_pkg

// File: rtl/gain_mul_serial.sv
// Bit-serial shift-add multiplier: signed operand times unsigned Q0.FRAC_W gain,
// one gain bit per step, LSB first. result_c is the scaled product that the
// accumulator will hold after the current step.
// Build option: CORDIC_GAIN_ROUND_EN preloads the accumulator with half an LSB
// so the result rounds half up instead of truncating.
module gain_mul_serial #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FRAC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic signed [WIDTH-1:0]  op_i,
  input  logic                     kbit_i,
  input  logic [$clog2(2*WIDTH)-1:0] idx_i,
  output logic signed [WIDTH-1:0]  result_c
);

  localparam int unsigned ACC_W = 2 * WIDTH;

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic [ACC_W-1:0] PRELOAD = ACC_W'(1) << (FRAC_W - 1);
`else
  localparam logic [ACC_W-1:0] PRELOAD = '0;
`endif

  logic signed [WIDTH-1:0] op_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [ACC_W-1:0]        op_ext;
  logic [ACC_W-1:0]        addend;

  assign op_ext = {{WIDTH{op_q[WIDTH-1]}}, op_q};

  // Next accumulator value: add the shifted operand when the gain bit is set.
  always_comb begin
    addend = '0;
    if (kbit_i) begin
      addend = op_ext << idx_i;
    end
    acc_d = acc_q + addend;
  end

  assign result_c = acc_d[FRAC_W +: WIDTH];

  // Operand capture on load, accumulation on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      op_q  <= op_i;
      acc_q <= PRELOAD;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

endmodule : gain_mul_serial

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: multiplies x/y by the Q0.16 gain KGAIN using two
// bit-serial multipliers, with a valid/ready handshake on both sides.
// Build option: CORDIC_GAIN_ROUND_EN selects round-half-up instead of truncation.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int unsigned        WIDTH = WIDTH_DEF,
  parameter logic [KGAIN_W-1:0] KGAIN = KGAIN_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    busy
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SH_W  = $clog2(ACC_W);
  localparam logic [ACC_W-1:0] KGAIN_EXT = ACC_W'(KGAIN);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d;
  logic signed [WIDTH-1:0] y_out_q, y_out_d;

  logic                    load_c;
  logic                    step_c;
  logic [SH_W-1:0]         idx_c;
  logic                    kbit_c;
  logic signed [WIDTH-1:0] x_res_c;
  logic signed [WIDTH-1:0] y_res_c;

  assign idx_c  = SH_W'(cnt_q);
  assign kbit_c = KGAIN_EXT[idx_c];

  gain_mul_serial #(.WIDTH(WIDTH), .FRAC_W(KGAIN_W)) u_mul_x (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (load_c),
    .step_i   (step_c),
    .op_i     (x_in),
    .kbit_i   (kbit_c),
    .idx_i    (idx_c),
    .result_c (x_res_c)
  );

  gain_mul_serial #(.WIDTH(WIDTH), .FRAC_W(KGAIN_W)) u_mul_y (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (load_c),
    .step_i   (step_c),
    .op_i     (y_in),
    .kbit_i   (kbit_c),
    .idx_i    (idx_c),
    .result_c (y_res_c)
  );

  // Next-state and registered-output logic for the accept / multiply / hold cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    load_c      = 1'b0;
    step_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_c     = 1'b1;
          cnt_d      = '0;
          state_d    = MUL;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      MUL: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          x_out_d     = x_res_c;
          y_out_d     = y_res_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

endmodule : cordic_gain_comp

// File: doc/cordic_gain_comp.md
CORDIC_GAIN_COMP -- requirements
Module: cordic_gain_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the signed data inputs and outputs.
REQ-002 SHALL have parameter KGAIN, default 16'h9B74: unsigned Q0.16 CORDIC gain constant (0.60725 = 39796/65536).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  x_in/y_in valid; driven from the rotational CORDIC data_out_rot.
REQ-006 SHALL have port in_ready  output  1  block can accept a sample.
REQ-007 SHALL have port x_in  input  WIDTH  signed two's-complement xprime from the CORDIC.
REQ-008 SHALL have port y_in  input  WIDTH  signed two's-complement yprime from the CORDIC.
REQ-009 SHALL have port out_valid  output  1  x_out/y_out hold a compensated result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port x_out  output  WIDTH  signed gain-compensated x.
REQ-012 SHALL have port y_out  output  WIDTH  signed gain-compensated y.
REQ-013 SHALL have port busy  output  1  high in states MUL and DONE.

Function
REQ-014 SHALL implement FSM states IDLE, MUL and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, on an edge with in_valid=1 in IDLE, capture x_in and y_in, clear both 2*WIDTH accumulators and the bit counter, and enter MUL.
REQ-017 SHALL, in MUL, process one KGAIN bit per cycle, LSB first, adding the sign-extended operand shifted left by the bit index when the bit is 1; x and y run in parallel.
REQ-018 SHALL stay in MUL for exactly WIDTH cycles; the counter runs 0..WIDTH-1 with no wrap beyond.
REQ-019 SHALL, on the last MUL edge, register x_out=(x*KGAIN)>>>16 and y_out=(y*KGAIN)>>>16 (arithmetic shift, floor) and enter DONE.
REQ-020 SHALL raise out_valid exactly WIDTH edges after the accept edge.
REQ-021 SHALL hold out_valid, x_out and y_out stable in DONE until out_ready=1; that edge returns to IDLE.
REQ-022 SHALL NOT accept input in the edge that leaves DONE; minimum interval between accepts is WIDTH+2 cycles.
REQ-023 SHALL ignore in_valid outside IDLE and SHALL NOT buffer it.
REQ-024 SHALL keep x_out/y_out unchanged in IDLE after a transfer; out_valid SHALL be 0 in IDLE and MUL.
REQ-025 SHALL never overflow, since KGAIN<1.0; x=-2^(WIDTH-1) needs no special case.

Reset
REQ-026 SHALL, on reset=0 at any time including mid-MUL or DONE, immediately set state=IDLE, in_ready=1, out_valid=0, busy=0, x_out=0, y_out=0, and clear the accumulators and counter.
REQ-027 SHALL take its first sample on the first rising edge with reset=1 and in_valid=1.

Configuration
REQ-028 SHALL, with macro CORDIC_GAIN_ROUND_EN defined, compute outputs as (v*KGAIN + 2^15)>>>16, rounding half up, by preloading each accumulator with 2^15 at accept.
REQ-029 SHALL, without CORDIC_GAIN_ROUND_EN, use pure truncation per REQ-019; latency and handshake are identical in both builds.

Structure
REQ-030 SHALL take WIDTH default, KGAIN constant and the state enum typedef from shared package cordic_pkg.
REQ-031 SHALL implement the serial shift-add datapath as sub-module gain_mul_serial, instantiated twice (x, y), with the FSM and counter in cordic_gain_comp.

Verification
REQ-032 Bench SHALL check: x_in=1000, y_in=-1000, accept at edge E -> out_valid at E+16; truncating x_out=607, y_out=-608; rounding x_out=607, y_out=-607.
REQ-033 Bench SHALL check: x_in=32767, y_in=-32768 -> x_out=19897, y_out=-19898 in both builds.
REQ-034 Bench SHALL check: out_ready held 0 for 5 cycles in DONE -> out_valid and data stable, in_ready=0; a second in_valid is ignored.
REQ-035 Bench SHALL check: reset=0 asserted 4 cycles into MUL -> out_valid=0, x_out=y_out=0, in_ready=1 with no clock edge needed; the next sample computes correctly.
REQ-036 Bench SHALL check: in_valid held high with out_ready=1 -> accepts every 18 cycles; each result matches the reference model.
REQ-037 Bench SHALL check: x_in=0, y_in=1 -> x_out=0, y_out=0 truncating, y_out=1 rounding.
